alu_host_link: RTL and testbench

ALU_HOST_LINK -- requirements
Module: alu_host_link

---
 rtl/alu_host_link.sv | 162 ++++++++++++++++
 tb/tb_alu_host_link.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_host_link.sv
// alu_host_link: host-side initiator for the UART ALU link.
// Sends one command packet (opcode, operand A LSB-first, operand B LSB-first)
// and then assembles one little-endian response packet.
// Optional feature: define ALU_HOST_LINK_TIMEOUT_EN to end RECV after
// TIMEOUT_CYCLES_P silent cycles with rsp_timeout_o=1.
module alu_host_link #(
  parameter int OPERAND_WIDTH_P  = 32,
  parameter int TIMEOUT_CYCLES_P = 100000
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [7:0]                 cmd_opcode_i,
  input  logic [OPERAND_WIDTH_P-1:0] cmd_a_i,
  input  logic [OPERAND_WIDTH_P-1:0] cmd_b_i,
  output logic [7:0]                 tx_data_o,
  output logic                       tx_valid_o,
  input  logic                       tx_ready_i,
  input  logic [7:0]                 rx_data_i,
  input  logic                       rx_valid_i,
  output logic                       rx_ready_o,
  output logic                       rsp_valid_o,
  input  logic                       rsp_ready_i,
  output logic [OPERAND_WIDTH_P-1:0] rsp_data_o,
  output logic                       rsp_timeout_o
);
  localparam int NB        = OPERAND_WIDTH_P / 8;
  localparam int PKT_BYTES = 1 + 2 * NB;
  localparam int PKT_W     = 8 * PKT_BYTES;
  localparam int IDX_W     = $clog2(PKT_BYTES + 1);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_e;

  state_e                     state_q, state_d;
  // Packet shift register: the byte on the wire is always bits [7:0].
  logic [PKT_W-1:0]           pkt_q, pkt_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic                       tx_valid_q, tx_valid_d;
  logic [OPERAND_WIDTH_P-1:0] rsp_q, rsp_d;
  // Goes high on the first edge after reset release; gates the ready outputs.
  logic                       live_q;
  logic                       tx_hs, rx_hs;

`ifdef ALU_HOST_LINK_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES_P + 1);
  logic [TW-1:0] cnt_q, cnt_d;
  logic          tmo_q, tmo_d;
`endif

  assign tx_hs       = tx_valid_q && tx_ready_i;
  assign rx_hs       = rx_valid_i && rx_ready_o;
  assign cmd_ready_o = live_q && (state_q == IDLE);
  // Bytes arriving outside RECV are accepted and dropped to flush the line.
  assign rx_ready_o  = live_q && (state_q != DONE);
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = pkt_q[7:0];
  assign rsp_valid_o = (state_q == DONE);
  assign rsp_data_o  = rsp_q;
`ifdef ALU_HOST_LINK_TIMEOUT_EN
  assign rsp_timeout_o = tmo_q;
`else
  assign rsp_timeout_o = 1'b0;
`endif

  // Next-state and datapath updates for the IDLE/SEND/RECV/DONE sequence.
  always_comb begin
    state_d    = state_q;
    pkt_d      = pkt_q;
    idx_d      = idx_q;
    tx_valid_d = tx_valid_q;
    rsp_d      = rsp_q;
`ifdef ALU_HOST_LINK_TIMEOUT_EN
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (cmd_valid_i && cmd_ready_o) begin
          pkt_d      = {cmd_b_i, cmd_a_i, cmd_opcode_i};
          idx_d      = '0;
          tx_valid_d = 1'b1;
          state_d    = SEND;
        end
      end
      SEND: begin
        if (tx_hs) begin
          pkt_d = pkt_q >> 8;
          if (idx_q == IDX_W'(PKT_BYTES - 1)) begin
            state_d    = RECV;
            tx_valid_d = 1'b0;
            idx_d      = '0;
            rsp_d      = '0;
`ifdef ALU_HOST_LINK_TIMEOUT_EN
            cnt_d      = '0;
            tmo_d      = 1'b0;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      RECV: begin
        if (rx_hs) begin
          for (int k = 0; k < NB; k++)
            if (idx_q == IDX_W'(k)) rsp_d[k*8 +: 8] = rx_data_i;
`ifdef ALU_HOST_LINK_TIMEOUT_EN
          cnt_d = '0;
`endif
          if (idx_q == IDX_W'(NB - 1)) state_d = DONE;
          else                         idx_d   = idx_q + 1'b1;
`ifdef ALU_HOST_LINK_TIMEOUT_EN
        end else if (cnt_q == TW'(TIMEOUT_CYCLES_P - 1)) begin
          // Partial result is kept as-is; only the flag marks it incomplete.
          cnt_d   = cnt_q + 1'b1;
          tmo_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
`endif
        end
      end
      DONE: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any transaction in flight.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q    <= IDLE;
      pkt_q      <= '0;
      idx_q      <= '0;
      tx_valid_q <= 1'b0;
      rsp_q      <= '0;
      live_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pkt_q      <= pkt_d;
      idx_q      <= idx_d;
      tx_valid_q <= tx_valid_d;
      rsp_q      <= rsp_d;
      live_q     <= 1'b1;
    end
  end

`ifdef ALU_HOST_LINK_TIMEOUT_EN
  // Silence counter and timeout flag.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
`endif

endmodule

// File: tb/tb_alu_host_link.sv
module tb_alu_host_link;
  localparam int W = 32;
  localparam int T = 16;

  logic clk = 1'b0;
  logic reset_ni;
  logic cmd_valid_i, cmd_ready_o;
  logic [7:0] cmd_opcode_i;
  logic [W-1:0] cmd_a_i, cmd_b_i;
  logic [7:0] tx_data_o;
  logic tx_valid_o, tx_ready_i;
  logic [7:0] rx_data_i;
  logic rx_valid_i, rx_ready_o;
  logic rsp_valid_o, rsp_ready_i;
  logic [W-1:0] rsp_data_o;
  logic rsp_timeout_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_host_link #(.OPERAND_WIDTH_P(W), .TIMEOUT_CYCLES_P(T)) dut (
    .clk_i(clk), .reset_ni(reset_ni),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_opcode_i(cmd_opcode_i), .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_data_o(rsp_data_o), .rsp_timeout_o(rsp_timeout_o)
  );

  // mode: 0 = tx_ready always 1, 1 = toggling, 2 = random with rx gaps
  typedef struct {
    logic [7:0]       op;
    logic [31:0]      a, b;
    int               mode;
    logic [3:0][7:0]  rx;      // rx[0] is sent first
    int               stall;
    bit               flush;
    logic [31:0]      exp_rsp;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Expected wire order: opcode, then A and B each least significant byte first.
  function automatic void model_tx(input logic [7:0] op, input logic [31:0] a,
                                   input logic [31:0] b, output logic [7:0] q[$]);
    q = {};
    q.push_back(op);
    for (int k = 0; k < 4; k++) q.push_back(8'((a >> (8 * k)) & 32'hFF));
    for (int k = 0; k < 4; k++) q.push_back(8'((b >> (8 * k)) & 32'hFF));
  endfunction

  task automatic offer_cmd(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    cmd_opcode_i = op; cmd_a_i = a; cmd_b_i = b; cmd_valid_i = 1'b1;
    while (!cmd_ready_o && n < 20) begin step(); n++; end
    chk("cmd_ready_wait", 64'(n < 20), 64'd1);
    chk("tx_idle_before_accept", 64'(tx_valid_o), 64'd0);
    step();
    cmd_valid_i = 1'b0;
  endtask

  // Push n tx bytes with tx_ready held high; stops right after the nth handshake.
  task automatic send_bytes(input logic [7:0] op, input logic [31:0] a,
                            input logic [31:0] b, input int n);
    int done = 0, cyc = 0;
    offer_cmd(op, a, b);
    tx_ready_i = 1'b1;
    while (done < n && cyc < 100) begin
      if (tx_valid_o) done++;
      step(); cyc++;
    end
    tx_ready_i = 1'b0;
    chk("send_bytes_done", 64'(done), 64'(n));
  endtask

  task automatic send_rx(input logic [7:0] d);
    rx_valid_i = 1'b1; rx_data_i = d;
    chk("rx_ready_recv", 64'(rx_ready_o), 64'd1);
    step();
    rx_valid_i = 1'b0;
  endtask

  task automatic run_txn(input vec_t v);
    logic [7:0] exp_tx[$];
    logic [7:0] prev;
    bit stalled = 0;
    int i = 0, cyc = 0, n;
    model_tx(v.op, v.a, v.b, exp_tx);
    if (v.flush) begin
      rx_valid_i = 1'b1; rx_data_i = 8'hEE;
      chk("flush_idle_ready", 64'(rx_ready_o), 64'd1);
      step();
      rx_valid_i = 1'b0;
    end
    offer_cmd(v.op, v.a, v.b);
    while (i < 9 && cyc < 200) begin
      chk("tx_valid_send", 64'(tx_valid_o), 64'd1);
      if (stalled) chk("tx_stable", 64'(tx_data_o), 64'(prev));
      tx_ready_i = (v.mode == 0) ? 1'b1 : (v.mode == 1) ? cyc[0] : 1'($urandom_range(0, 1));
      rx_valid_i = v.flush; rx_data_i = 8'hEE;
      if (tx_ready_i && tx_valid_o) begin
        chk($sformatf("tx_byte%0d", i), 64'(tx_data_o), 64'(exp_tx[i]));
        i++;
        stalled = 0;
      end else stalled = 1;
      prev = tx_data_o;
      step(); cyc++;
    end
    tx_ready_i = 1'b0; rx_valid_i = 1'b0;
    chk("tx_all_sent", 64'(i), 64'd9);
    if (v.mode == 0) chk("tx_back_to_back", 64'(cyc), 64'd9);
    chk("tx_valid_recv", 64'(tx_valid_o), 64'd0);
    chk("rsp_cleared_recv", 64'(rsp_data_o), 64'd0);
    for (int k = 0; k < 4; k++) begin
      if (v.mode == 2) repeat ($urandom_range(0, 2)) step();
      send_rx(v.rx[k]);
    end
    chk("rsp_valid", 64'(rsp_valid_o), 64'd1);
    chk("rsp_data", 64'(rsp_data_o), 64'(v.exp_rsp));
    chk("rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    chk("cmd_ready_done", 64'(cmd_ready_o), 64'd0);
    for (n = 0; n < v.stall; n++) begin
      step();
      chk("rsp_hold_valid", 64'(rsp_valid_o), 64'd1);
      chk("rsp_hold_data", 64'(rsp_data_o), 64'(v.exp_rsp));
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("rsp_valid_after", 64'(rsp_valid_o), 64'd0);
    chk("cmd_ready_after", 64'(cmd_ready_o), 64'd1);
  endtask

  vec_t vecs[10];

  initial begin
    int seen;
    reset_ni = 1'b0; cmd_valid_i = 1'b0; cmd_opcode_i = '0; cmd_a_i = '0; cmd_b_i = '0;
    tx_ready_i = 1'b0; rx_data_i = '0; rx_valid_i = 1'b0; rsp_ready_i = 1'b0;

    vecs[0] = '{8'h01, 32'h11223344, 32'hAABBCCDD, 0, {8'h12, 8'h34, 8'h56, 8'h78}, 0, 0, 32'h12345678};
    vecs[1] = '{8'h02, 32'hDEADBEEF, 32'h00000001, 1, {8'h04, 8'h03, 8'h02, 8'h01}, 5, 0, 32'h04030201};
    vecs[2] = '{8'h03, 32'h00000000, 32'hFFFFFFFF, 0, {8'h01, 8'hEF, 8'hCD, 8'hAB}, 1, 1, 32'h01EFCDAB};
    vecs[3] = '{8'hFF, 32'hFFFFFFFF, 32'h80000000, 2, {8'h80, 8'h00, 8'h00, 8'h00}, 2, 1, 32'h80000000};
    for (int j = 4; j < 10; j++) begin
      vecs[j].op = 8'($urandom); vecs[j].a = $urandom; vecs[j].b = $urandom;
      vecs[j].mode = $urandom_range(0, 2); vecs[j].stall = $urandom_range(0, 3);
      vecs[j].flush = 1'($urandom_range(0, 1));
      vecs[j].exp_rsp = '0;
      for (int k = 0; k < 4; k++) begin
        vecs[j].rx[k] = 8'($urandom);
        vecs[j].exp_rsp = vecs[j].exp_rsp | (32'(vecs[j].rx[k]) << (8 * k));
      end
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    chk("rst_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("rst_rx_ready", 64'(rx_ready_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("rst_rsp_timeout", 64'(rsp_timeout_o), 64'd0);
    chk("rst_rsp_data", 64'(rsp_data_o), 64'd0);
    reset_ni = 1'b1;
    #1;
    chk("rel_cmd_ready_before_edge", 64'(cmd_ready_o), 64'd0);
    step();
    chk("rel_cmd_ready_after_edge", 64'(cmd_ready_o), 64'd1);
    chk("rel_rx_ready", 64'(rx_ready_o), 64'd1);

    foreach (vecs[j]) run_txn(vecs[j]);

    // Reset after the fourth SEND byte: transaction abandoned at once.
    send_bytes(8'h55, 32'hCAFEF00D, 32'h01020304, 4);
    chk("mid_send_tx_valid", 64'(tx_valid_o), 64'd1);
    reset_ni = 1'b0;
    #1;
    chk("mid_send_rst_tx_valid", 64'(tx_valid_o), 64'd0);
    chk("mid_send_rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
    #2 reset_ni = 1'b1;
    step();
    run_txn(vecs[0]);

    // Reset mid-RECV: no partial response survives.
    send_bytes(8'h10, 32'h1, 32'h2, 9);
    send_rx(8'h99);
    send_rx(8'h88);
    reset_ni = 1'b0;
    #1;
    chk("mid_recv_rst_valid", 64'(rsp_valid_o), 64'd0);
    chk("mid_recv_rst_data", 64'(rsp_data_o), 64'd0);
    #2 reset_ni = 1'b1;
    step();
    run_txn(vecs[1]);

    // Two response bytes then silence.
    send_bytes(8'h20, 32'h3, 32'h4, 9);
    send_rx(8'hAA);
    send_rx(8'hBB);
`ifdef ALU_HOST_LINK_TIMEOUT_EN
    seen = 0;
    while (!rsp_valid_o && seen < 40) begin step(); seen++; end
    chk("timeout_cycles", 64'(seen), 64'(T));
    chk("timeout_flag", 64'(rsp_timeout_o), 64'd1);
    chk("timeout_partial", 64'(rsp_data_o), 64'h0000BBAA);
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("timeout_cmd_ready", 64'(cmd_ready_o), 64'd1);
`else
    seen = 0;
    repeat (1000) begin
      if (rsp_valid_o) seen++;
      step();
    end
    chk("no_timeout_valid", 64'(seen), 64'd0);
    chk("no_timeout_still_recv", 64'(rx_ready_o), 64'd1);
    chk("no_timeout_partial", 64'(rsp_data_o), 64'h0000BBAA);
    reset_ni = 1'b0;
    #2 reset_ni = 1'b1;
    step();
`endif
    run_txn(vecs[2]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
